// File: rtl/quad_pkg.sv
// Shared widths and pipeline-stage types for the quad_sched sum-of-squares scheduler.
// Operands are unsigned 2.12, squares 4.24, results 5.24.
package quad_pkg;

   localparam int OP_W  = 14;
   localparam int SQ_W  = 28;
   localparam int RES_W = 29;
   localparam int ID_W  = 3;   // wide enough for the largest requester count (8)

   typedef struct packed {
      logic                valid;
      logic [ID_W-1:0]     id;
      logic [2*SQ_W-1:0]   data;   // {a^2, b^2}
   } sq_stage_t;

   typedef struct packed {
      logic                valid;
      logic [ID_W-1:0]     id;
      logic [RES_W-1:0]    data;   // a^2 + b^2, already truncated
   } sum_stage_t;

   // Keeps the top (2 + fwl) bits of a 2.12 operand.
   function automatic logic [OP_W-1:0] op_mask(input int fwl);
      return ~((OP_W'(1) << (12 - fwl)) - OP_W'(1));
   endfunction

   // Keeps the top (5 + fwl) bits of a 5.24 result.
   function automatic logic [RES_W-1:0] res_mask(input int fwl);
      return ~((RES_W'(1) << (24 - fwl)) - RES_W'(1));
   endfunction

endpackage

// File: rtl/quad_core.sv
// Two-stage truncating sum-of-squares pipeline with a valid/id side-band.
// Never stalls: the issuer guarantees every stage-2 result has somewhere to go.
import quad_pkg::*;

module quad_core #(
   parameter int FWL_A = 10,
   parameter int FWL_B = 9,
   parameter int FWL_C = 13
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid_i,
   input  logic [ID_W-1:0]  in_id_i,
   input  logic [OP_W-1:0]  in_a_i,
   input  logic [OP_W-1:0]  in_b_i,
   output logic             s1_valid_o,
   output sum_stage_t       s2_o
);

   localparam logic [OP_W-1:0]  MASK_A = op_mask(FWL_A);
   localparam logic [OP_W-1:0]  MASK_B = op_mask(FWL_B);
   localparam logic [RES_W-1:0] MASK_C = res_mask(FWL_C);

   sq_stage_t        s1_q, s1_d;
   sum_stage_t       s2_q, s2_d;
   logic [OP_W-1:0]  a_t, b_t;
   logic [RES_W-1:0] sum;

   always_comb begin
      a_t        = in_a_i & MASK_A;
      b_t        = in_b_i & MASK_B;
      s1_d.valid = in_valid_i;
      s1_d.id    = in_id_i;
      s1_d.data  = {SQ_W'(a_t) * SQ_W'(a_t), SQ_W'(b_t) * SQ_W'(b_t)};

      // Each square is below 16, so the 29-bit sum cannot overflow.
      sum        = RES_W'(s1_q.data[2*SQ_W-1:SQ_W]) + RES_W'(s1_q.data[SQ_W-1:0]);
      s2_d.valid = s1_q.valid;
      s2_d.id    = s1_q.id;
      s2_d.data  = sum & MASK_C;
   end

   // Only the valid bits need clearing; data is qualified by them.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      if (!rstn) begin
         s1_q.valid <= 1'b0;
         s2_q.valid <= 1'b0;
      end
   end

   assign s1_valid_o = s1_q.valid;
   assign s2_o       = s2_q;

endmodule

// File: rtl/quad_sched.sv
// Round-robin scheduler sharing one sum-of-squares pipeline between NREQ requesters,
// with a credit-guarded result FIFO. Define QUAD_SCHED_STATS_EN for issue/stall counters.
import quad_pkg::*;

module quad_sched #(
   parameter int NREQ   = 4,
   parameter int FWL_A  = 10,
   parameter int FWL_B  = 9,
   parameter int FWL_C  = 13,
   parameter int RDEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NREQ-1:0]               req_valid,
   output logic [NREQ-1:0]               req_ready,
   input  logic [NREQ-1:0][OP_W-1:0]     req_a,
   input  logic [NREQ-1:0][OP_W-1:0]     req_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [$clog2(NREQ)-1:0]       rsp_id,
   output logic [RES_W-1:0]              rsp_c
`ifdef QUAD_SCHED_STATS_EN
   ,
   output logic [31:0]                   stat_issued,
   output logic [31:0]                   stat_stall
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = IDW + 1;
   localparam int PW  = $clog2(RDEPTH);
   localparam int OW  = PW + 2;
   localparam int EW  = IDW + RES_W;

   logic [IDW-1:0]  rr_q, rr_d;
   logic [PW:0]     count_q, count_d;
   logic [PW-1:0]   wr_q, rd_q;
   logic [EW-1:0]   mem_q [RDEPTH];
   logic [EW-1:0]   head;

   logic            s1_valid;
   sum_stage_t      s2;
   logic [OW-1:0]   occ;
   logic            issue_ok, gnt_found, grant, push, pop;
   logic [IDW-1:0]  gnt_idx;
   logic [CW-1:0]   cand;
   logic            unused_id;

   // Round-robin search starting at rr_q, wrapping modulo NREQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_q} + CW'(k);
         if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
         if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
      rr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
   end

   // Every issued operand already owns a FIFO slot, so stage 2 never has to wait.
   assign occ      = OW'(count_q) + OW'(s1_valid) + OW'(s2.valid);
   assign issue_ok = occ < OW'(RDEPTH);
   assign grant    = rstn & issue_ok & gnt_found;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = grant & (gnt_idx == IDW'(gi));
      end
   endgenerate

   quad_core #(
      .FWL_A (FWL_A),
      .FWL_B (FWL_B),
      .FWL_C (FWL_C)
   ) u_core (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid_i (grant),
      .in_id_i    (ID_W'(gnt_idx)),
      .in_a_i     (req_a[gnt_idx]),
      .in_b_i     (req_b[gnt_idx]),
      .s1_valid_o (s1_valid),
      .s2_o       (s2)
   );

   // The shared id field is sized for NREQ=8; narrower configurations ignore the top bits.
   assign unused_id = ^s2.id;

   assign push    = s2.valid;
   assign pop     = rsp_valid & rsp_ready;
   assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

   assign head      = mem_q[rd_q];
   assign rsp_valid = rstn & (count_q != '0);
   assign rsp_id    = rsp_valid ? head[EW-1:RES_W] : '0;
   assign rsp_c     = rsp_valid ? head[RES_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {s2.id[IDW-1:0], s2.data};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         rr_q    <= '0;
      end else begin
         count_q <= count_d;
         if (push)  wr_q <= wr_q + PW'(1);
         if (pop)   rd_q <= rd_q + PW'(1);
         if (grant) rr_q <= rr_d;
      end
   end

`ifdef QUAD_SCHED_STATS_EN
   logic [31:0] issued_q, stall_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         if (grant && issued_q != '1) issued_q <= issued_q + 32'd1;
         if ((|req_valid) && !grant && stall_q != '1) stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_issued = issued_q;
   assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_quad_sched.sv
// Scoreboard bench for quad_sched: grants are modelled round-robin and pushed with the
// expected sum of squares; results are popped and compared as they leave the FIFO.
`timescale 1ns/1ps
module tb_quad_sched;
   import quad_pkg::*;

   localparam int NREQ = 4, FWL_A = 10, FWL_B = 9, FWL_C = 13, RDEPTH = 4;

   logic                      clk = 1'b0;
   logic                      rstn;
   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ-1:0][13:0]     req_a, req_b;
   logic                      rsp_valid, rsp_ready;
   logic [1:0]                rsp_id;
   logic [28:0]               rsp_c;
`ifdef QUAD_SCHED_STATS_EN
   logic [31:0]               stat_issued, stat_stall;
`endif

   always #5 clk = ~clk;

   quad_sched #(
      .NREQ(NREQ), .FWL_A(FWL_A), .FWL_B(FWL_B), .FWL_C(FWL_C), .RDEPTH(RDEPTH)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c)
`ifdef QUAD_SCHED_STATS_EN
      , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
   );

   typedef struct { int id; logic [28:0] c; } exp_t;
   exp_t sb[$];

   int n_tests = 0, n_fail = 0;
   int n_grants = 0, n_pops = 0, n_gr_rst = 0;
   int rr_m = 0;
   logic [NREQ-1:0] acc = '0;
   logic [NREQ-1:0] auto_en = '0;
   logic rand_ready = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [28:0] model_c(input logic [13:0] a, input logic [13:0] b);
      longint at, bt, c;
      at = (longint'(a) >> (12 - FWL_A)) << (12 - FWL_A);
      bt = (longint'(b) >> (12 - FWL_B)) << (12 - FWL_B);
      c  = at * at + bt * bt;
      c  = (c >> (24 - FWL_C)) << (24 - FWL_C);
      return c[28:0];
   endfunction

   // Monitor: sample on the falling edge, away from the active edge.
   initial begin
      int   e, c;
      exp_t x;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            sb.delete();
            rr_m     = 0;
            acc      = '0;
            n_gr_rst = 0;
         end else begin
            acc = req_valid & req_ready;
            if (req_ready != '0) begin
               e = -1;
               for (int k = 0; k < NREQ; k++) begin
                  c = (rr_m + k) % NREQ;
                  if (e < 0 && req_valid[c]) e = c;
               end
               check_val("rr_grant", 64'(req_ready), (e >= 0) ? (64'd1 << e) : 64'd0);
               if (e >= 0) begin
                  x.id = e;
                  x.c  = model_c(req_a[e], req_b[e]);
                  sb.push_back(x);
                  rr_m = (e + 1) % NREQ;
               end
               n_grants++;
               n_gr_rst++;
            end
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  check_val("rsp_unexpected", 64'd1, 64'd0);
               end else begin
                  x = sb.pop_front();
                  $display("[TB] rsp id=%0d c=0x%07h (exp id=%0d c=0x%07h)", rsp_id, rsp_c, x.id, x.c);
                  check_val("rsp_id", 64'(rsp_id), 64'(x.id));
                  check_val("rsp_c", 64'(rsp_c), 64'(x.c));
               end
               n_pops++;
            end
         end
      end
   end

   // Requester/consumer driver: replace operands after acceptance, or withdraw.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
               if (auto_en[i]) begin
                  req_a[i] = 14'($urandom_range(0, 16383));
                  req_b[i] = 14'($urandom_range(0, 16383));
               end else begin
                  req_valid[i] = 1'b0;
               end
            end
         end
         if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic at_drive();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (k < 60 && (req_valid != '0 || sb.size() != 0)) begin
         @(negedge clk);
         k++;
      end
      check_val(tag, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int g0, p0, found;
      logic [31:0] s0;
      rstn       = 1'b0;
      req_valid  = '1;
      rsp_ready  = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i] = 14'h3fff;
         req_b[i] = 14'h3fff;
      end
      repeat (3) @(negedge clk);
      check_val("rst_req_ready", 64'(req_ready), 64'd0);
      check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_val("rst_rsp_id", 64'(rsp_id), 64'd0);
      check_val("rst_rsp_c", 64'(rsp_c), 64'd0);
`ifdef QUAD_SCHED_STATS_EN
      check_val("rst_stat_issued", 64'(stat_issued), 64'd0);
      check_val("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif

      // Single request straight out of reset: grant in first cycle, result at T+3.
      at_drive();
      rstn      = 1'b1;
      req_valid = 4'b0001;
      req_a[0]  = 14'h1000;
      req_b[0]  = 14'h1000;
      @(negedge clk);
      check_val("first_grant", 64'(req_ready), 64'd1);
      @(negedge clk);
      check_val("lat_t1_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check_val("lat_t2_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check_val("lat_t3_valid", 64'(rsp_valid), 64'd1);
      check_val("lat_t3_id", 64'(rsp_id), 64'd0);
      check_val("lat_t3_c", 64'(rsp_c), 64'h2000000);

      // Operand truncation on requester 2.
      at_drive();
      req_valid[2] = 1'b1;
      req_a[2]     = 14'h1003;
      req_b[2]     = 14'h0803;
      found = 0;
      for (int k = 0; k < 10 && found == 0; k++) begin
         @(negedge clk);
         if (rsp_valid) found = 1;
      end
      check_val("trunc_rsp_seen", 64'(found), 64'd1);
      check_val("trunc_id", 64'(rsp_id), 64'd2);
      check_val("trunc_c", 64'(rsp_c), 64'h1400000);
      drain("drain_trunc");

      // All requesters busy, consumer always ready: one grant and one result per cycle.
      at_drive();
      rsp_ready = 1'b1;
      auto_en   = '1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i] = 14'($urandom_range(0, 16383));
         req_b[i] = 14'($urandom_range(0, 16383));
      end
      req_a[3]  = 14'h3fff;
      req_b[3]  = 14'h3fff;
      req_valid = '1;
      g0 = n_grants;
      p0 = n_pops;
      repeat (40) @(posedge clk);
      #2;
      check_val("tput_grants", 64'(n_grants - g0), 64'd40);
      check_val("tput_pops", 64'(n_pops - p0), 64'd37);
      auto_en = '0;
      drain("drain_tput");

      // Consumer stalled: credits allow exactly RDEPTH grants.
      at_drive();
      rsp_ready = 1'b0;
      auto_en   = '1;
      req_valid = '1;
      g0 = n_grants;
      repeat (12) @(posedge clk);
      #2;
      check_val("full_grants", 64'(n_grants - g0), 64'(RDEPTH));
      @(negedge clk);
      check_val("full_ready", 64'(req_ready), 64'd0);
`ifdef QUAD_SCHED_STATS_EN
      check_val("stat_issued", 64'(stat_issued), 64'(n_gr_rst));
      s0 = stat_stall;
      repeat (5) @(negedge clk);
      check_val("stat_stall_delta", 64'(stat_stall - s0), 64'd5);
`else
      s0 = 32'd0;
`endif

      // Single-cycle pops on a full FIFO each free exactly one credit.
      for (int p = 0; p < 3; p++) begin
         at_drive();
         rsp_ready = 1'b1;
         g0 = n_grants;
         at_drive();
         rsp_ready = 1'b0;
         repeat (6) @(posedge clk);
         #2;
         check_val("pulse_grants", 64'(n_grants - g0), 64'd1);
         check_val("pulse_valid", 64'(rsp_valid), 64'd1);
      end

      // Random consumer backpressure; ordering and completeness via the scoreboard.
      at_drive();
      rand_ready = 1'b1;
      repeat (60) @(posedge clk);
      #2;
      rand_ready = 1'b0;
      rsp_ready  = 1'b1;
      auto_en    = '0;
      drain("drain_rand");

      // Reset with two results queued and two in flight.
      at_drive();
      rsp_ready = 1'b0;
      auto_en   = '1;
      req_valid = '1;
      g0 = n_grants;
      repeat (4) @(posedge clk);
      #2;
      check_val("pre_rst_grants", 64'(n_grants - g0), 64'd4);
      rstn = 1'b0;
      @(negedge clk);
      check_val("in_rst_valid", 64'(rsp_valid), 64'd0);
      check_val("in_rst_ready", 64'(req_ready), 64'd0);
      at_drive();
      rstn      = 1'b1;
      rsp_ready = 1'b1;
      auto_en   = '0;
      p0 = n_pops;
      @(negedge clk);
      check_val("post_rst_valid", 64'(rsp_valid), 64'd0);
      check_val("post_rst_grant", 64'(req_ready), 64'd1);
      drain("drain_rst");
      repeat (4) @(negedge clk);
      check_val("post_rst_pops", 64'(n_pops - p0), 64'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/quad_sched.md
QUAD_SCHED -- requirements
Module: quad_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one sum-of-squares datapath, range 2..8.
REQ-002 Parameter FWL_A, default 10: fractional bits of operand a kept, range 0..12.
REQ-003 Parameter FWL_B, default 9: fractional bits of operand b kept, range 0..12.
REQ-004 Parameter FWL_C, default 13: fractional bits of result c kept, range 0..24.
REQ-005 Parameter RDEPTH, default 4: result FIFO depth, power of two, minimum 2.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rstn  in  1  reset, synchronous, active-low.
REQ-008 req_valid  in  NREQ  per-requester operand valid.
REQ-009 req_ready  out  NREQ  per-requester accept, one-hot or zero.
REQ-010 req_a  in  NREQ x 14  unsigned operand a per requester, format 2.12.
REQ-011 req_b  in  NREQ x 14  unsigned operand b per requester, format 2.12.
REQ-012 rsp_valid  out  1  result available at FIFO head.
REQ-013 rsp_ready  in  1  consumer accepts head result.
REQ-014 rsp_id  out  clog2(NREQ)  index of the requester that owns the head result.
REQ-015 rsp_c  out  29  unsigned result, format 5.24.

Function
REQ-016 Handshake: transfer on valid&ready; a requester holds req_a/req_b stable until accepted; the consumer side follows the same rule.
REQ-017 Issue allowed only when fifo_count + inflight < RDEPTH; inflight = number of valid datapath stages (0..2).
REQ-018 At most one grant per cycle; req_ready[i] = issue_allowed & req_valid[i] & (i selected by round-robin).
REQ-019 Round-robin: search starts at the index after the last granted requester and wraps modulo NREQ; pointer = 0 after reset; pointer updates only on a grant.
REQ-020 Operand truncation: a keeps bits [13:12-FWL_A], b keeps bits [13:12-FWL_B], lower bits forced to 0; FWL=12 passes the operand unchanged.
REQ-021 Datapath: stage 1 registers a^2 and b^2 (28 bits each); stage 2 registers the 29-bit sum, no overflow possible; each stage carries a valid bit and the requester id.
REQ-022 Result truncation: c keeps bits [28:24-FWL_C], lower bits 0; FWL_C=24 passes unchanged.
REQ-023 Latency: operands accepted in cycle T give rsp_valid=1 in cycle T+3 if the FIFO was empty; results leave in issue order.
REQ-024 FIFO full plus a pop in the same cycle: a stage-2 result is written in that cycle and the count is unchanged.
REQ-025 The credit rule guarantees a stage-2 result always has a slot; the FIFO never overflows and never drops a result.
REQ-026 rsp_valid=0 with rsp_ready=1: no state change; rsp_id and rsp_c are don't-care while rsp_valid=0.
REQ-027 Throughput: one result per cycle sustained when rsp_ready is held at 1.

Reset
REQ-028 While rstn=0: req_ready=0, rsp_valid=0, rsp_id=0, rsp_c=0, pipeline valids=0, FIFO empty, RR pointer=0.
REQ-029 Reset mid-operation discards in-flight and queued results; the first grant is possible in the first cycle with rstn=1.

Configuration
REQ-030 Macro QUAD_SCHED_STATS_EN defined: adds outputs stat_issued (32-bit, counts grants) and stat_stall (32-bit, counts cycles with any req_valid=1 and no grant); both saturate, are cleared by reset, and are registered.
REQ-031 Macro QUAD_SCHED_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.

Structure
REQ-032 Package quad_pkg holds the operand width (14), result width (29), the sq width (28) constants and the typedef of the pipeline stage struct {valid, id, data}.
REQ-033 Sub-module quad_core: the truncating two-stage sum-of-squares pipeline, with a valid/id side-band and no backpressure; the arbiter, credit logic and FIFO stay in quad_sched.

Verification
REQ-034 Req0 a=0x1000, b=0x1000, defaults, FIFO empty -> cycle T+3: rsp_valid=1, rsp_id=0, rsp_c=0x2000000.
REQ-035 Req2 a=0x1003, b=0x0803 (FWL_A=10, FWL_B=9) -> truncated to 0x1000 and 0x0800 -> rsp_c=0x1400000 after the FWL_C mask.
REQ-036 All 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0..., rsp_id follows the same order, one result per cycle.
REQ-037 rsp_ready=0 with all requesters valid -> exactly RDEPTH=4 grants, then req_ready=0; with the stats macro on, stat_stall increments every later cycle.
REQ-038 rsp_ready pulsed on a full FIFO while stage 2 is valid -> count stays 4 and no result is lost (check by result ordering).
REQ-039 rstn=0 for one cycle with 2 results queued and 2 in flight -> rsp_valid=0 the next cycle; after release the results carry only new requests.
